// File: rtl/insn_fetch_unit_pkg.sv
// Shared fetch-stage definitions: default widths, NOP encoding, reset PC and FSM states.
package insn_fetch_unit_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [0:INSTR_W-1] NOP_INSN     = 32'h6000_0000;
    localparam logic [0:PC_W-1]    RESET_PC_DEF = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/insn_fetch_unit_fetch_queue.sv
// fetch_queue: small FIFO of {PC, instruction}; flush beats push, head holds still while not popped.
module insn_fetch_unit_fetch_queue #(
    parameter int unsigned              PC_WIDTH    = 32,
    parameter int unsigned              INSTR_WIDTH = 32,
    parameter int unsigned              DEPTH       = 2,
    parameter logic [0:INSTR_WIDTH-1]   EMPTY_INSN  = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [0:PC_WIDTH-1]          push_pc,
    input  logic [0:INSTR_WIDTH-1]       push_insn,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         valid,
    output logic [0:PC_WIDTH-1]          head_pc,
    output logic [0:INSTR_WIDTH-1]       head_insn
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [0:PC_WIDTH-1]    pc;
        logic [0:INSTR_WIDTH-1] insn;
    } entry_t;

    entry_t              mem [DEPTH];
    logic [AW-1:0]       rd_ptr, wr_ptr;
    logic [0:PC_WIDTH-1] last_pc;

    assign valid     = (count != '0);
    assign head_insn = valid ? mem[rd_ptr].insn : EMPTY_INSN;
    assign head_pc   = valid ? mem[rd_ptr].pc   : last_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            last_pc <= '0;
        end else begin
            // The converter keeps seeing the last PC after the queue drains or flushes.
            if (valid)
                last_pc <= mem[rd_ptr].pc;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Push into a full queue only happens alongside a pop, so overwriting the head slot is safe.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= '{pc: push_pc, insn: push_insn};
    end

endmodule

// File: rtl/insn_fetch_unit.sv
// Instruction fetch: sequential PC, req/ack to imem, 2-entry queue to the converter, redirect flush.
// Optional FETCH_ALIGN_CHECK_EN: flag misaligned redirect targets on misalign_o.
module insn_fetch_unit
    import insn_fetch_unit_pkg::*;
#(
    parameter int unsigned         PC_WIDTH    = PC_W,
    parameter int unsigned         INSTR_WIDTH = INSTR_W,
    parameter logic [0:PC_WIDTH-1] RESET_PC    = PC_WIDTH'(RESET_PC_DEF),
    parameter int unsigned         QUEUE_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall_i,
    input  logic                   redirect_i,
    input  logic [0:PC_WIDTH-1]    redirect_pc_i,
    output logic                   imem_req_o,
    output logic [0:PC_WIDTH-1]    imem_addr_o,
    input  logic                   imem_ack_i,
    input  logic [0:INSTR_WIDTH-1] imem_rdata_i,
    output logic                   insn_valid_o,
    output logic [0:INSTR_WIDTH-1] insn_o,
    output logic [0:PC_WIDTH-1]    insn_pc_o,
    output logic                   misalign_o
);
    localparam int unsigned         CW         = $clog2(QUEUE_DEPTH + 1);
    localparam logic [0:PC_WIDTH-1] ALIGN_MASK = ~PC_WIDTH'(3);

    fetch_state_e        state, state_nxt;
    logic [0:PC_WIDTH-1] fetch_pc, fetch_pc_nxt, drop_addr, redirect_tgt;
    logic [CW-1:0]       q_count, cnt_after_pop;
    logic                q_valid, pop, push, flush, room, room_after_push;

    assign redirect_tgt    = redirect_pc_i & ALIGN_MASK;
    assign pop             = q_valid && !stall_i;
    assign cnt_after_pop   = q_count - CW'(pop);
    assign room            = cnt_after_pop < CW'(QUEUE_DEPTH);
    assign room_after_push = (cnt_after_pop + CW'(1)) < CW'(QUEUE_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            fetch_pc  <= RESET_PC;
            drop_addr <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            // The abandoned request keeps its address on the bus until memory acks it.
            if (state == ST_REQ && redirect_i && !imem_ack_i)
                drop_addr <= fetch_pc;
        end
    end

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        push         = 1'b0;
        flush        = 1'b0;
        imem_req_o   = 1'b0;
        imem_addr_o  = fetch_pc;
        case (state)
            ST_IDLE: begin
                if (redirect_i) begin
                    flush        = 1'b1;
                    fetch_pc_nxt = redirect_tgt;
                    state_nxt    = ST_REQ;
                end else if (room) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                imem_req_o = 1'b1;
                if (redirect_i) begin
                    flush        = 1'b1;
                    fetch_pc_nxt = redirect_tgt;
                    state_nxt    = imem_ack_i ? ST_REQ : ST_DROP;
                end else if (imem_ack_i) begin
                    push         = 1'b1;
                    fetch_pc_nxt = fetch_pc + PC_WIDTH'(4);
                    state_nxt    = room_after_push ? ST_REQ : ST_IDLE;
                end
            end
            ST_DROP: begin
                imem_req_o  = 1'b1;
                imem_addr_o = drop_addr;
                if (redirect_i) begin
                    flush        = 1'b1;
                    fetch_pc_nxt = redirect_tgt;
                end
                // Once the stale request completes there is nothing left to drop, even on a new redirect.
                if (imem_ack_i)
                    state_nxt = ST_REQ;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    insn_fetch_unit_fetch_queue #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH),
        .DEPTH       (QUEUE_DEPTH),
        .EMPTY_INSN  (INSTR_WIDTH'(NOP_INSN))
    ) u_fetch_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_pc   (fetch_pc),
        .push_insn (imem_rdata_i),
        .count     (q_count),
        .valid     (q_valid),
        .head_pc   (insn_pc_o),
        .head_insn (insn_o)
    );

    assign insn_valid_o = q_valid;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            misalign_q <= 1'b0;
        else
            misalign_q <= redirect_i && (redirect_pc_i[PC_WIDTH-2:PC_WIDTH-1] != 2'b00);
    end
    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

endmodule
